// File: rtl/bcd_cnt.sv
// Single-digit BCD up/down counter with built-in prescaler, synchronous load
// and a one-cycle carry/borrow pulse for cascading further digits.
module bcd_cnt #(
  parameter int unsigned DIV = 50_000_000,
  parameter int unsigned PW  = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] dig,
  output logic       co
);

  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    dig_q, dig_d;
  logic          co_q,  co_d;
  logic          step;

  // A step fires on the same edge the prescaler wraps; with DIV=1 that is every enabled edge.
  always_comb begin
    step = en && (pre_q == PRE_MAX);
  end

  always_comb begin
    pre_d = pre_q;
    if (ld) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = step ? '0 : pre_q + PW'(1);
    end
  end

  always_comb begin
    dig_d = dig_q;
    co_d  = 1'b0;
    if (ld) begin
      dig_d = (ld_val > 4'd9) ? 4'd9 : ld_val;
    end else if (step) begin
      if (up) begin
        if (dig_q == 4'd9) begin
          dig_d = 4'd0;
          co_d  = 1'b1;
        end else begin
          dig_d = dig_q + 4'd1;
        end
      end else begin
        if (dig_q == 4'd0) begin
          dig_d = 4'd9;
          co_d  = 1'b1;
        end else begin
          dig_d = dig_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      dig_q <= '0;
      co_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      dig_q <= dig_d;
      co_q  <= co_d;
    end
  end

  assign dig = dig_q;
  assign co  = co_q;

endmodule

// File: tb/tb_bcd_cnt.sv
// Randomised and directed bench for bcd_cnt (DIV=4) against an arithmetic
// reference model of the digit, prescaler and carry/borrow pulse.
module tb_bcd_cnt;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       up  = 1'b1;
  logic       ld  = 1'b0;
  logic [3:0] ld_val = '0;
  logic [3:0] dig;
  logic       co;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_pre = 0;
  int m_dig = 0;
  int m_co  = 0;

  bcd_cnt #(.DIV(DIV), .PW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .up     (up),
    .ld     (ld),
    .ld_val (ld_val),
    .dig    (dig),
    .co     (co)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (dig <= 4'd9) else $error("dig out of range: %0d", dig);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pre = 0; m_dig = 0; m_co = 0;
    end else if (ld) begin
      m_dig = (int'(ld_val) > 9) ? 9 : int'(ld_val);
      m_pre = 0; m_co = 0;
    end else begin
      m_co = 0;
      if (en) begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          if (up) begin
            if (m_dig == 9) m_co = 1;
            m_dig = (m_dig + 1) % 10;
          end else begin
            if (m_dig == 0) m_co = 1;
            m_dig = (m_dig + 9) % 10;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  endtask

  // Apply the currently driven inputs for one edge, then compare.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_eq({tag, ".dig"}, int'(dig), m_dig);
    check_eq({tag, ".co"},  int'(co),  m_co);
    check_eq({tag, ".pre"}, int'(dut.pre_q), m_pre);
    check_eq({tag, ".range"}, int'(dig <= 4'd9), 1);
  endtask

  task automatic run_until_pre(input int target, input string tag);
    int k;
    for (k = 0; k < 3 * DIV && m_pre != target; k++) cycle(tag);
    check_eq({tag, ".reach_pre"}, m_pre, target);
  endtask

  initial begin
    int co_count;
    @(negedge clk);

    // 1) reset then count up
    rst = 1'b1;
    cycle("rst"); cycle("rst");
    check_eq("reset.dig", int'(dig), 0);
    rst = 1'b0; en = 1'b1; up = 1'b1;
    co_count = 0;
    for (int i = 0; i < 48; i++) begin
      cycle("up");
      if (co) co_count++;
    end
    check_eq("up.co_pulses", co_count, 1);

    // 2) from 3 count down through the borrow
    ld = 1'b1; ld_val = 4'd3;
    cycle("ld3");
    ld = 1'b0; up = 1'b0;
    co_count = 0;
    for (int i = 0; i < 20; i++) begin
      cycle("down");
      if (co) co_count++;
    end
    check_eq("down.co_pulses", co_count, 1);
    check_eq("down.final", int'(dig), 8);

    // 3) freeze mid-count at pre=2
    up = 1'b1;
    run_until_pre(2, "pre2");
    en = 1'b0;
    for (int i = 0; i < 10; i++) cycle("hold");
    en = 1'b1;
    for (int i = 0; i < 8; i++) cycle("resume");

    // 4) loads, including one on a step-due edge
    ld = 1'b1; ld_val = 4'd7;
    cycle("ld7");
    ld = 1'b0;
    cycle("ld7run"); cycle("ld7run");
    ld = 1'b1; ld_val = 4'hC;
    cycle("ldC");
    check_eq("ldC.clamp", int'(dig), 9);
    ld = 1'b0;
    run_until_pre(3, "due");
    ld = 1'b1; ld_val = 4'd7;
    cycle("ld_drop");
    check_eq("ld_drop.dig", int'(dig), 7);
    ld = 1'b0;
    for (int i = 0; i < 8; i++) cycle("after_ld");

    // 5) reset beats load and step
    run_until_pre(3, "due2");
    rst = 1'b1; ld = 1'b1; ld_val = 4'd5; en = 1'b1;
    cycle("rst_prio");
    check_eq("rst_prio.dig", int'(dig), 0);
    rst = 1'b0; ld = 1'b0;

    // 6) random stimulus
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      ld     = ($urandom_range(0, 11) == 0);
      en     = ($urandom_range(0, 3) != 0);
      up     = $urandom_range(0, 1) == 1;
      ld_val = 4'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
